// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 64;
  localparam int FETCH_INSTR_W = 32;
  localparam logic [5:0] OPC_B = 6'b000101;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Sign-extended 26-bit word offset scaled to a byte offset.
  function automatic logic [63:0] se26_shift2(input logic [25:0] imm);
    return {{36{imm[25]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: instruction-memory port, redirect input and decode handshake.
interface fetch_queue_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               deq_ready;
  logic               deq_valid;
  logic [INSTR_W-1:0] deq_instr;
  logic [ADDR_W-1:0]  deq_pc;
  logic [ADDR_W-1:0]  deq_pc_plus4;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output imem_req, imem_addr, deq_valid, deq_instr, deq_pc, deq_pc_plus4, occupancy,
    input  imem_rdata, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  imem_req, imem_addr, deq_valid, deq_instr, deq_pc, deq_pc_plus4, occupancy,
    output imem_rdata, redirect_valid, redirect_pc, deq_ready
  );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Circular buffer of fetched entries; DEPTH need not be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  entry_t                       wr_data,
  input  logic                         rd_en,
  output entry_t                       rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop      = rd_en && (count != '0);
  assign rd_valid = (count != '0);
  assign rd_data  = mem[head];

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Storage is cleared too so the head outputs are never X while empty.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        mem[tail] <= wr_data;
        tail      <= ptr_next(tail);
      end
      if (pop) head <= ptr_next(head);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch PC, 1-cycle instruction-memory issue, redirect squash and decode queue.
// Optional unconditional-branch folding is enabled by defining UNCOND_BR_FOLD_EN.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_queue_unit_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              issue;
  logic              wr_en;
  logic [CNT_W:0]    pending;
  logic [CNT_W-1:0]  count;
  entry_t            wr_entry;
  entry_t            head_entry;

  assign pending = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign issue   = rst && !bus.redirect_valid && (pending < (CNT_W + 1)'(DEPTH));
  // A response arriving during a redirect cycle belongs to the flushed stream.
  assign wr_en   = inflight && !bus.redirect_valid;

  assign wr_entry.instr = bus.imem_rdata;
  assign wr_entry.pc    = inflight_pc;

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = fetch_pc;
  assign bus.deq_instr    = head_entry.instr;
  assign bus.deq_pc       = head_entry.pc;
  assign bus.deq_pc_plus4 = head_entry.pc + ADDR_W'(4);
  assign bus.occupancy    = count;

`ifdef UNCOND_BR_FOLD_EN
  logic [63:0]       br_off;
  logic              fold_hit;
  logic [ADDR_W-1:0] fold_target;

  assign br_off      = se26_shift2(bus.imem_rdata[25:0]);
  assign fold_hit    = wr_en && (bus.imem_rdata[31:26] == OPC_B);
  assign fold_target = inflight_pc + br_off[ADDR_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~ADDR_W'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end
`ifdef UNCOND_BR_FOLD_EN
      // Retarget and drop the sequential fetch issued alongside the B enqueue.
      if (fold_hit) begin
        fetch_pc <= fold_target;
        inflight <= 1'b0;
      end
`endif
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_valid),
    .wr_en    (wr_en),
    .wr_data  (wr_entry),
    .rd_en    (bus.deq_ready),
    .rd_data  (head_entry),
    .rd_valid (bus.deq_valid),
    .count    (count)
  );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: two instances (RESET_PC 0 and near-wrap).
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  logic clk;
  logic rst0, rst1;
  logic b_at_40;
  int   vectors;
  int   miscompares;
  bit   found;

  fetch_queue_unit_if #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4)) bus0 ();
  fetch_queue_unit_if #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4)) bus1 ();

  fetch_queue_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4), .RESET_PC(64'h0)) dut0 (
    .clk (clk), .rst (rst0), .bus (bus0)
  );
  fetch_queue_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(4),
                     .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word index as data; B with offset -2 at 0x40 when enabled.
  always @(posedge clk) begin
    bus0.imem_rdata <= (b_at_40 && bus0.imem_addr == 64'h40) ? 32'h17FF_FFFE
                                                            : bus0.imem_addr[33:2];
    bus1.imem_rdata <= bus1.imem_addr[33:2];
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst0 = 1'b0; rst1 = 1'b0; b_at_40 = 1'b0;
    bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0; bus0.deq_ready = 1'b1;
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0; bus1.deq_ready = 1'b1;

    // Reset state
    step(); step(); #1;
    chk("rst_req", 64'(bus0.imem_req), 64'd0);
    chk("rst_valid", 64'(bus0.deq_valid), 64'd0);
    chk("rst_occ", 64'(bus0.occupancy), 64'd0);
    chk("rst_instr_not_x", 64'(bus0.deq_instr), 64'd0);

    // c0: first request at RESET_PC
    step(); rst0 = 1'b1; #1;
    chk("c0_req", 64'(bus0.imem_req), 64'd1);
    chk("c0_addr", bus0.imem_addr, 64'h0);
    chk("c0_valid", 64'(bus0.deq_valid), 64'd0);
    step(); #1;
    chk("c1_addr", bus0.imem_addr, 64'h4);
    chk("c1_valid", 64'(bus0.deq_valid), 64'd0);

    // Streaming from c2, one instruction per cycle
    step(); #1;
    for (int k = 0; k < 4; k++) begin
      chk("stream_valid", 64'(bus0.deq_valid), 64'd1);
      chk("stream_pc", bus0.deq_pc, 64'(4 * k));
      chk("stream_instr", 64'(bus0.deq_instr), 64'(k));
      chk("stream_pc4", bus0.deq_pc_plus4, 64'(4 * k + 4));
      if (k == 0) chk("stream_occ", 64'(bus0.occupancy), 64'd1);
      step(); #1;
    end

    // Backpressure for 10 cycles: queue fills, fetch stops, head holds
    bus0.deq_ready = 1'b0;
    chk("stall_head", bus0.deq_pc, 64'h10);
    repeat (9) begin step(); #1; end
    chk("full_occ", 64'(bus0.occupancy), 64'd4);
    chk("full_req", 64'(bus0.imem_req), 64'd0);
    chk("full_pc", bus0.deq_pc, 64'h10);
    chk("full_instr", 64'(bus0.deq_instr), 64'd4);
    chk("full_valid", 64'(bus0.deq_valid), 64'd1);
    step(); bus0.deq_ready = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      chk("drain_valid", 64'(bus0.deq_valid), 64'd1);
      chk("drain_pc", bus0.deq_pc, 64'(64'h10 + 4 * i));
      step(); #1;
    end

    // Redirect with 3 queued and 1 in flight; low address bits ignored
    bus0.deq_ready = 1'b0;
    step(); #1;
    chk("pre_redir_occ", 64'(bus0.occupancy), 64'd3);
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 64'h103; #1;
    chk("redir_req", 64'(bus0.imem_req), 64'd0);
    step(); bus0.redirect_valid = 1'b0; bus0.deq_ready = 1'b1; #1;
    chk("redir1_valid", 64'(bus0.deq_valid), 64'd0);
    chk("redir1_occ", 64'(bus0.occupancy), 64'd0);
    chk("redir1_req", 64'(bus0.imem_req), 64'd1);
    chk("redir1_addr", bus0.imem_addr, 64'h100);
    step(); #1;
    chk("redir2_valid", 64'(bus0.deq_valid), 64'd0);
    step(); #1;
    chk("redir3_pc", bus0.deq_pc, 64'h100);
    chk("redir3_valid", 64'(bus0.deq_valid), 64'd1);
    chk("redir3_instr", 64'(bus0.deq_instr), 64'h40);
    step(); #1;
    chk("redir4_pc", bus0.deq_pc, 64'h104);

    // Redirect coinciding with a dequeue fire
    step(); #1;
    chk("fire_pc", bus0.deq_pc, 64'h108);
    chk("fire_valid", 64'(bus0.deq_valid), 64'd1);
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 64'h200; #1;
    step(); bus0.redirect_valid = 1'b0; #1;
    chk("fire1_valid", 64'(bus0.deq_valid), 64'd0);
    step(); #1;
    chk("fire2_valid", 64'(bus0.deq_valid), 64'd0);
    step(); #1;
    chk("fire3_pc", bus0.deq_pc, 64'h200);
    step(); #1;
    chk("fire4_pc", bus0.deq_pc, 64'h204);

    // Unconditional branch at 0x40 with offset -2 words
    b_at_40 = 1'b1;
    bus0.redirect_valid = 1'b1; bus0.redirect_pc = 64'h40; #1;
    step(); bus0.redirect_valid = 1'b0; #1;
    chk("b_req_addr", bus0.imem_addr, 64'h40);
    step(); #1;
    step(); #1;
    chk("b_pc", bus0.deq_pc, 64'h40);
    chk("b_instr", 64'(bus0.deq_instr), 64'h17FF_FFFE);
    found = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step(); #1;
      if (bus0.deq_valid) begin found = 1'b1; break; end
    end
    chk("b_next_seen", 64'(found), 64'd1);
`ifdef UNCOND_BR_FOLD_EN
    chk("b_next_pc", bus0.deq_pc, 64'h38);
`else
    chk("b_next_pc", bus0.deq_pc, 64'h44);
`endif

    // Near-wrap RESET_PC and mid-stream reset
    step(); rst1 = 1'b1; #1;
    chk("w0_addr", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    step(); step(); #1;
    chk("w2_pc", bus1.deq_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("w2_instr", 64'(bus1.deq_instr), 64'hFFFF_FFFE);
    step(); #1;
    chk("w3_pc", bus1.deq_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w3_pc4", bus1.deq_pc_plus4, 64'h0);
    step(); #1;
    chk("w4_pc", bus1.deq_pc, 64'h0);
    step(); #1;
    chk("w5_pc", bus1.deq_pc, 64'h4);
    step(); rst1 = 1'b0; #1;
    chk("mrst_req", 64'(bus1.imem_req), 64'd0);
    step(); #1;
    chk("mrst_valid", 64'(bus1.deq_valid), 64'd0);
    chk("mrst_occ", 64'(bus1.occupancy), 64'd0);
    chk("mrst_req2", 64'(bus1.imem_req), 64'd0);
    step(); rst1 = 1'b1; #1;
    chk("restart_req", 64'(bus1.imem_req), 64'd1);
    chk("restart_addr", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    step(); step(); #1;
    chk("restart_pc", bus1.deq_pc, 64'hFFFF_FFFF_FFFF_FFF8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
